seq_mul4: RTL
=============

SEQ_MUL4 -- requirements
Module: seq_mul4

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits; supported range 2..8.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port a, input, W, multiplicand; captured on the accepting edge.
REQ-006 SHALL have port b, input, W, multiplier; captured on the accepting edge.
REQ-007 SHALL have port busy, output, 1, high while in RUN.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when product becomes valid.
REQ-009 SHALL have port product, output, 2W, unsigned a*b; held stable from done until next accepting edge.

Function
REQ-010 SHALL implement unsigned shift-and-add multiplication, one partial-product step per clock.
REQ-011 SHALL use three states: IDLE, RUN, DONE.
REQ-012 SHALL register M (W), Q (W), accumulator A (W), carry bit C, step counter (ceil(log2(W+1)) bits).
REQ-013 SHALL, in IDLE with start=1 at an edge (accepting edge), load M=a, Q=b, A=0, C=0, counter=0, and go to RUN.
REQ-014 SHALL, in IDLE with start=0, hold all registers and product.
REQ-015 SHALL, per RUN edge: if Q[0]=1, {C,A}=A+M (W-bit add, carry-in 0), else {C,A}={0,A}; then {C,A,Q} shifts right one bit with 0 into MSB; counter increments.
REQ-016 SHALL leave RUN for DONE on the edge where counter reaches W; exactly W RUN edges per operation.
REQ-017 SHALL, in DONE, drive done=1 and product={A,Q}; next edge unconditionally returns to IDLE.
REQ-018 SHALL give latency W edges from accepting edge to done high (W=4: done high in the cycle after edge 4).
REQ-019 SHALL ignore start while in RUN or DONE; no queuing.
REQ-020 SHALL keep product updated only on entry to DONE; intermediate A/Q never appear on product.
REQ-021 SHALL accept a new start on the first IDLE edge after DONE (back-to-back throughput W+2 cycles).
REQ-022 SHALL treat operand zero normally (full W steps, product 0); no early termination.
REQ-023 SHALL ensure carry out of the add never overflows product: max (2^W-1)^2 fits 2W bits.

Reset
REQ-024 SHALL, when rst=1 at an edge, force state=IDLE, busy=0, done=0, product=0, M=Q=A=C=counter=0.
REQ-025 SHALL give rst priority over start and over any RUN/DONE transition.
REQ-026 SHALL abort an in-flight operation on reset mid-RUN; no done pulse for it.

Structure
REQ-027 SHALL place state enum typedef (IDLE/RUN/DONE) and default W constant in shared package mul_pkg.
REQ-028 SHALL instantiate one combinational sub-module addw (W-bit ripple adder: a, b, cin -> sum, cout) for the partial-product add.
REQ-029 SHALL keep all sequential logic in seq_mul4; addw contains no state.

Verification
REQ-030 SHALL cover: W=4, a=3, b=5, start 1 cycle -> busy 4 cycles, done 1 cycle, product=0x0F.
REQ-031 SHALL cover: a=15, b=15 -> product=0xE1 (225), carry path exercised every step.
REQ-032 SHALL cover: a=0, b=9 and a=9, b=0 -> product=0x00, still exactly 4 busy cycles.
REQ-033 SHALL cover: start held high through RUN with changing a/b -> result of first captured operands only, then new op accepted in IDLE after DONE.
REQ-034 SHALL cover: rst asserted at 2nd RUN edge -> next cycle busy=0, done=0, product=0, no done pulse.
REQ-035 SHALL cover: exhaustive 256 operand pairs back-to-back -> every product equals a*b, done count 256.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the sequential multiplier
//
// Purpose: FSM state encoding, default operand width and the step-counter
//          width helper used by seq_mul4.
// Ports:   none (package).

package mul_pkg;

  // Default operand width; the design supports 2..8.
  localparam int W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The step counter must be able to hold the value W, so it needs
  // ceil(log2(W+1)) bits.
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/addw.sv
// rtl/addw.sv - W-bit combinational ripple-carry adder
//
// Purpose: partial-product adder for seq_mul4; holds no state.
// Ports:
//   a    in  W  addend
//   b    in  W  addend
//   cin  in  1  carry in
//   sum  out W  a + b + cin, low W bits
//   cout out 1  carry out of bit W-1

module addw #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_mul4.sv
// rtl/seq_mul4.sv - unsigned shift-and-add sequential multiplier
//
// Purpose: multiplies two W-bit unsigned operands in W clock steps,
//          one partial product per clock, and presents the 2W-bit
//          product with a one-cycle done pulse.
// Ports:
//   clk     in  1   clock, rising edge
//   rst     in  1   synchronous active-high reset
//   start   in  1   begin a multiply (sampled only in IDLE)
//   a       in  W   multiplicand, captured on the accepting edge
//   b       in  W   multiplier, captured on the accepting edge
//   busy    out 1   high while in RUN
//   done    out 1   one-cycle pulse, product valid
//   product out 2W  a*b, held from done until the next accepting edge

module seq_mul4
  import mul_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = cnt_bits(W);

  state_t          state_q, state_d;
  logic [W-1:0]    m_q, m_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    a_q, a_d;
  logic            c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  prod_q, prod_d;

  logic [W-1:0]    add_sum;
  logic            add_cout;
  logic [W-1:0]    step_a;
  logic            step_c;
  logic [W-1:0]    shift_a;
  logic [W-1:0]    shift_q;

  // C is cleared on load and by every shift, so it is zero at the start
  // of each step; feeding it as carry-in gives the plain A+M add.
  addw #(.W(W)) u_addw (
    .a    (a_q),
    .b    (m_q),
    .cin  (c_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // One partial-product step: conditional add, then {C,A,Q} >> 1.
  always_comb begin
    step_c  = q_q[0] ? add_cout : 1'b0;
    step_a  = q_q[0] ? add_sum  : a_q;
    shift_a = {step_c, step_a[W-1:1]};
    shift_q = {step_a[0], q_q[W-1:1]};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        busy  = 1'b1;
        a_d   = shift_a;
        q_d   = shift_q;
        c_d   = 1'b0;
        cnt_d = cnt_q + 1'b1;
        // Last step: capture the finished product so intermediate A/Q
        // never reach the output.
        if (cnt_q == CW'(W - 1)) begin
          prod_d  = {shift_a, shift_q};
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign product = prod_q;

endmodule
